me_search_ctrl: RTL and testbench

Sequencing controller for the motion-estimation core `me`. It takes one macroblock search request and splits the search window into horizontal strips. For each strip it runs the `me` start/ready/en_ram handshake and drives the current-block and search-window read addresses column by column. It keeps the minimum SAD across all strips and reports the best SAD and the strip that produced it, with a one-cycle done pulse.

---
 rtl/me_search_ctrl_if.sv | 32 +++
 rtl/me_search_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_me_search_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_search_ctrl_if.sv
// me_search_ctrl_if
// Groups the signals between the search controller, the motion-estimation
// core `me` and the two pixel memories (current block, search window).
//   me_ready / me_start / me_en_ram / me_valid / me_min_sad : core handshake
//   sw_rd_en / sw_row / sw_col                              : search-window column read
//   cur_rd_en / cur_col                                     : current-block column read
// master = controller side, slave = core/memory side.
interface me_search_ctrl_if #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
);
  logic                          me_ready;
  logic                          me_start;
  logic                          me_en_ram;
  logic                          me_valid;
  logic [15:0]                   me_min_sad;
  logic                          sw_rd_en;
  logic [$clog2(SEARCH_DIM)-1:0] sw_row;
  logic [$clog2(SEARCH_DIM)-1:0] sw_col;
  logic                          cur_rd_en;
  logic [$clog2(MACRO_DIM)-1:0]  cur_col;

  modport master (
    input  me_ready, me_en_ram, me_valid, me_min_sad,
    output me_start, sw_rd_en, sw_row, sw_col, cur_rd_en, cur_col
  );

  modport slave (
    output me_ready, me_en_ram, me_valid, me_min_sad,
    input  me_start, sw_rd_en, sw_row, sw_col, cur_rd_en, cur_col
  );
endinterface

// File: rtl/me_search_ctrl.sv
// me_search_ctrl
// Splits one macroblock search window into horizontal strips (strip k starts
// at row 2k, each column read delivers MACRO_DIM+1 rows), runs the `me` core
// handshake once per strip, streams the column read addresses and keeps the
// smallest SAD seen together with the strip that produced it.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   start, abort     : search request (accepted in IDLE only) / cancel
//   busy, done       : search in progress / one-cycle completion pulse
//   best_sad         : minimum SAD over all finished strips
//   best_strip       : strip index that produced best_sad
//   bus (master)     : core handshake and memory read addresses
// All outputs are registered.
module me_search_ctrl #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [15:0] best_sad,
  output logic [$clog2((SEARCH_DIM-MACRO_DIM-1)/2+1)-1:0] best_strip,
  me_search_ctrl_if.master bus
);

  localparam int NUM_STRIPS = (SEARCH_DIM - MACRO_DIM - 1) / 2 + 1;
  localparam int STRIP_W    = $clog2(NUM_STRIPS);
  localparam int ADDR_W     = $clog2(SEARCH_DIM);
  localparam int CUR_W      = $clog2(MACRO_DIM);

  localparam logic [ADDR_W-1:0]  LAST_COL   = ADDR_W'(SEARCH_DIM - 1);
  localparam logic [ADDR_W-1:0]  CUR_COLS   = ADDR_W'(MACRO_DIM);
  localparam logic [STRIP_W-1:0] LAST_STRIP = STRIP_W'(NUM_STRIPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    START,
    WAIT_EN,
    STREAM,
    WAIT_RES,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [STRIP_W-1:0]  k_q, k_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                me_start_q, me_start_d;
  logic                sw_rd_en_q, sw_rd_en_d;
  logic [ADDR_W-1:0]   sw_row_q, sw_row_d;
  logic [ADDR_W-1:0]   sw_col_q, sw_col_d;
  logic                cur_rd_en_q, cur_rd_en_d;
  logic [CUR_W-1:0]    cur_col_q, cur_col_d;
  logic [15:0]         best_sad_q, best_sad_d;
  logic [STRIP_W-1:0]  best_strip_q, best_strip_d;
  logic [ADDR_W-1:0]   col_inc;

  // sw_col_q doubles as the stream column counter.
  assign col_inc = sw_col_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    me_start_d   = 1'b0;
    sw_rd_en_d   = sw_rd_en_q;
    sw_row_d     = sw_row_q;
    sw_col_d     = sw_col_q;
    cur_rd_en_d  = cur_rd_en_q;
    cur_col_d    = cur_col_q;
    best_sad_d   = best_sad_q;
    best_strip_d = best_strip_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d      = WAIT_RDY;
          busy_d       = 1'b1;
          k_d          = '0;
          best_sad_d   = 16'hFFFF;
          best_strip_d = '0;
        end
      end
      WAIT_RDY: begin
        if (bus.me_ready) begin
          state_d    = START;
          me_start_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_EN;
      end
      WAIT_EN: begin
        // Outputs are registered, so the first column read is launched here
        // and appears the cycle after me_en_ram is seen.
        if (bus.me_en_ram) begin
          state_d     = STREAM;
          sw_rd_en_d  = 1'b1;
          sw_row_d    = ADDR_W'({k_q, 1'b0});
          sw_col_d    = '0;
          cur_rd_en_d = 1'b1;
          cur_col_d   = '0;
        end
      end
      STREAM: begin
        // Runs for SEARCH_DIM cycles regardless of me_en_ram; the current
        // block is only MACRO_DIM columns wide so its reads stop early.
        if (sw_col_q == LAST_COL) begin
          state_d     = WAIT_RES;
          sw_rd_en_d  = 1'b0;
          cur_rd_en_d = 1'b0;
        end else begin
          sw_col_d    = col_inc;
          cur_rd_en_d = (col_inc < CUR_COLS);
          if (col_inc < CUR_COLS) begin
            cur_col_d = col_inc[CUR_W-1:0];
          end
        end
      end
      WAIT_RES: begin
        if (bus.me_valid) begin
          // Strict compare keeps the earliest strip on a tie.
          if (bus.me_min_sad < best_sad_q) begin
            best_sad_d   = bus.me_min_sad;
            best_strip_d = k_q;
          end
          if (k_q == LAST_STRIP) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = WAIT_RDY;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition above, including a result arriving
    // in the same cycle; the best-so-far values are left as they were.
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      k_d          = k_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      me_start_d   = 1'b0;
      sw_rd_en_d   = 1'b0;
      cur_rd_en_d  = 1'b0;
      best_sad_d   = best_sad_q;
      best_strip_d = best_strip_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      me_start_q   <= 1'b0;
      sw_rd_en_q   <= 1'b0;
      sw_row_q     <= '0;
      sw_col_q     <= '0;
      cur_rd_en_q  <= 1'b0;
      cur_col_q    <= '0;
      best_sad_q   <= 16'hFFFF;
      best_strip_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      me_start_q   <= me_start_d;
      sw_rd_en_q   <= sw_rd_en_d;
      sw_row_q     <= sw_row_d;
      sw_col_q     <= sw_col_d;
      cur_rd_en_q  <= cur_rd_en_d;
      cur_col_q    <= cur_col_d;
      best_sad_q   <= best_sad_d;
      best_strip_q <= best_strip_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign best_sad      = best_sad_q;
  assign best_strip    = best_strip_q;
  assign bus.me_start  = me_start_q;
  assign bus.sw_rd_en  = sw_rd_en_q;
  assign bus.sw_row    = sw_row_q;
  assign bus.sw_col    = sw_col_q;
  assign bus.cur_rd_en = cur_rd_en_q;
  assign bus.cur_col   = cur_col_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// tb_me_search_ctrl
// Directed bench for me_search_ctrl. A sequential core model answers each
// strip's handshake from a table of per-strip SADs; expected results are
// worked out by hand from those tables.
module tb_me_search_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] best_sad;
  logic [3:0]  best_strip;

  logic [15:0] sad_tbl [16];

  int n_checks;
  int n_fail;

  me_search_ctrl_if #(.MACRO_DIM(16), .SEARCH_DIM(48)) bus ();

  me_search_ctrl #(.MACRO_DIM(16), .SEARCH_DIM(48)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .best_sad   (best_sad),
    .best_strip (best_strip),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full search driven through the core model. Optional hooks: address
  // check on chk_strip, abort mid-stream on abort_strip, async reset in
  // WAIT_RES of rst_strip (-1 disables a hook).
  task automatic run_search(input int en_dly, input int res_dly, input int chk_strip,
                            input int abort_strip, input int rst_strip,
                            input logic [15:0] exp_sad, input logic [3:0] exp_strip);
    int cnt;
    bit got;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL busy_rise: got %b expected 1", busy);
    end
    for (int s = 0; s < 16; s++) begin
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (bus.me_start === 1'b1) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("[TB] FAIL me_start_timeout: strip %0d got no start, expected one", s);
        return;
      end
      @(negedge clk);
      n_checks++;
      if (bus.me_start !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL me_start_width: strip %0d got %b expected 0", s, bus.me_start);
      end
      repeat (en_dly - 1) @(negedge clk);
      bus.me_en_ram = 1'b1;
      @(negedge clk);
      bus.me_en_ram = 1'b0;
      cnt = 0;
      while (bus.sw_rd_en === 1'b1 && cnt < 100) begin
        if (s == chk_strip) begin
          n_checks++;
          if (bus.sw_row !== 6'(2 * s) || bus.sw_col !== 6'(cnt)) begin
            n_fail++;
            $display("[TB] FAIL sw_addr: col %0d got row %0d col %0d expected row %0d col %0d",
                     cnt, bus.sw_row, bus.sw_col, 2 * s, cnt);
          end
          n_checks++;
          if (bus.cur_rd_en !== (cnt < 16) || (cnt < 16 && bus.cur_col !== 4'(cnt))) begin
            n_fail++;
            $display("[TB] FAIL cur_addr: col %0d got en %b col %0d expected en %b col %0d",
                     cnt, bus.cur_rd_en, bus.cur_col, (cnt < 16), cnt % 16);
          end
        end
        if (s == abort_strip && cnt == 10) begin
          abort = 1'b1;
          bus.me_valid = 1'b1;
          bus.me_min_sad = 16'd1;
          @(negedge clk);
          abort = 1'b0;
          bus.me_valid = 1'b0;
          n_checks++;
          if ({busy, done, bus.sw_rd_en, bus.cur_rd_en} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL abort_outputs: got busy/done/sw/cur %b expected 0000",
                     {busy, done, bus.sw_rd_en, bus.cur_rd_en});
          end
          n_checks++;
          if (best_sad !== exp_sad || best_strip !== exp_strip) begin
            n_fail++;
            $display("[TB] FAIL abort_best: got %0d/%0d expected %0d/%0d",
                     best_sad, best_strip, exp_sad, exp_strip);
          end
          return;
        end
        cnt++;
        @(negedge clk);
      end
      n_checks++;
      if (cnt != 48) begin
        n_fail++;
        $display("[TB] FAIL stream_len: strip %0d got %0d expected 48", s, cnt);
      end
      if (s == rst_strip) begin
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, bus.me_start, bus.sw_rd_en, bus.cur_rd_en} !== 5'b0) begin
          n_fail++;
          $display("[TB] FAIL async_rst_ctl: got %b expected 00000",
                   {busy, done, bus.me_start, bus.sw_rd_en, bus.cur_rd_en});
        end
        n_checks++;
        if (bus.sw_row !== 6'd0 || bus.sw_col !== 6'd0 || bus.cur_col !== 4'd0) begin
          n_fail++;
          $display("[TB] FAIL async_rst_addr: got %0d/%0d/%0d expected 0/0/0",
                   bus.sw_row, bus.sw_col, bus.cur_col);
        end
        n_checks++;
        if (best_sad !== 16'hFFFF || best_strip !== 4'd0) begin
          n_fail++;
          $display("[TB] FAIL async_rst_best: got %h/%0d expected ffff/0", best_sad, best_strip);
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      repeat (res_dly) @(negedge clk);
      bus.me_valid = 1'b1;
      bus.me_min_sad = sad_tbl[s];
      @(negedge clk);
      bus.me_valid = 1'b0;
      n_checks++;
      if (done !== (s == 15)) begin
        n_fail++;
        $display("[TB] FAIL done_pulse: strip %0d got %b expected %b", s, done, (s == 15));
      end
    end
    n_checks++;
    if (best_sad !== exp_sad || best_strip !== exp_strip) begin
      n_fail++;
      $display("[TB] FAIL best_result: got %0d/%0d expected %0d/%0d",
               best_sad, best_strip, exp_sad, exp_strip);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_done: got done %b busy %b expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, bus.me_start, bus.sw_rd_en, bus.cur_rd_en} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctl: got %b expected 00000",
               {busy, done, bus.me_start, bus.sw_rd_en, bus.cur_rd_en});
    end
    n_checks++;
    if (bus.sw_row !== 6'd0 || bus.sw_col !== 6'd0 || bus.cur_col !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_addr: got %0d/%0d/%0d expected 0/0/0",
               bus.sw_row, bus.sw_col, bus.cur_col);
    end
    n_checks++;
    if (best_sad !== 16'hFFFF || best_strip !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_best: got %h/%0d expected ffff/0", best_sad, best_strip);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_search;
    for (int i = 0; i < 16; i++) sad_tbl[i] = 16'(1000 - 10 * i);
    run_search(2, 5, 3, -1, -1, 16'd850, 4'd15);
  endtask

  task automatic test_ties;
    for (int i = 0; i < 16; i++) sad_tbl[i] = 16'd600;
    sad_tbl[4] = 16'd500;
    sad_tbl[9] = 16'd500;
    run_search(1, 0, -1, -1, -1, 16'd500, 4'd4);
  endtask

  task automatic test_abort;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_with_abort: got busy %b expected 0", busy);
    end
    for (int i = 0; i < 16; i++) sad_tbl[i] = 16'(1000 - 10 * i);
    run_search(2, 5, -1, 2, -1, 16'd990, 4'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || bus.me_start !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL post_abort_quiet: got done %b me_start %b expected 0 0",
                 done, bus.me_start);
      end
    end
    run_search(2, 5, -1, -1, -1, 16'd850, 4'd15);
  endtask

  task automatic test_ignored_events;
    @(negedge clk);
    bus.me_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (bus.me_start !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL ready_low_start: cycle %0d got %b expected 0", i, bus.me_start);
      end
      start = (i == 5);
      @(negedge clk);
    end
    bus.me_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.me_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_rise_start: got %b expected 1", bus.me_start);
    end
    @(negedge clk);
    start = 1'b1;
    bus.me_valid = 1'b1;
    bus.me_min_sad = 16'd5;
    @(negedge clk);
    start = 1'b0;
    bus.me_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.me_start !== 1'b0 || bus.sw_rd_en !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL no_restart: got me_start %b sw_rd_en %b expected 0 0",
                 bus.me_start, bus.sw_rd_en);
      end
      @(negedge clk);
    end
    n_checks++;
    if (best_sad !== 16'hFFFF || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stray_valid: got best %h busy %b expected ffff 1", best_sad, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wait_en_abort: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 16; i++) sad_tbl[i] = 16'(1000 - 10 * i);
    run_search(1, 2, -1, -1, 1, 16'hFFFF, 4'd0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_rst: got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.me_ready = 1'b1;
    bus.me_en_ram = 1'b0;
    bus.me_valid = 1'b0;
    bus.me_min_sad = 16'd0;
    test_reset();
    test_basic_search();
    test_ties();
    test_abort();
    test_ignored_events();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
